// File: rtl/hk_spi_pkg.sv
// Shared definitions for the housekeeping SPI arbiter.
//   arb_state_e : transaction FSM states
//   CH_ADC/CH_DAC : SPI channel indices
//   SPI_DW : SPI data word width
//   clog2() : ceil(log2(v)), used to size counters and indices
package hk_spi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_HI,
    S_WAIT_LO,
    S_RESP
  } arb_state_e;

  localparam int CH_ADC = 0;
  localparam int CH_DAC = 1;
  localparam int SPI_DW = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/hk_rr_arbiter.sv
// Round-robin grant over NREQ requesters, purely combinational.
//   req     : request vector
//   ptr     : index of the last winner; the search starts just after it
//   en      : grant enable; no grant when low
//   gnt     : one-hot grant
//   gnt_idx : index of the granted requester
// The pointer register itself lives in the parent.
module hk_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx
);

  always_comb begin
    logic          found;
    logic [IW-1:0] idx;
    int            tmp;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    tmp     = 0;
    // Visit ptr+1, ptr+2, ... ptr (cyclic); the first live request wins.
    for (int i = 1; i <= NREQ; i++) begin
      tmp = (int'(ptr) + i) % NREQ;
      idx = IW'(tmp);
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/hk_spi_arbiter.sv
// Shares the two housekeeping SPI master channels (ADC, DAC) between NREQ
// requesters, one transaction at a time, round-robin.
//   clk_i, rstn_i          : clock, async active-low reset
//   req_valid_i/ready_o    : request handshake (ready is a 1-cycle accept)
//   req_ch_i, req_wr_h/l_i : per-requester channel select and write data
//   rsp_valid_o/data_o/err_o : completion pulse to the granted requester
//   spi_start_o, spi_wr_h/l_o : per-channel start pulse and write data
//   spi_rd_l_i, spi_bsy_i  : per-channel read data and busy
// Optional build macro HK_SPI_ARB_STATS_EN adds stat_xfer_o, stat_tmo_o and
// stat_last_lat_o counters.
module hk_spi_arbiter
  import hk_spi_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TMO_CYC = 32768,
  parameter int BSY_WIN = 4
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic [NREQ-1:0]              req_valid_i,
  output logic [NREQ-1:0]              req_ready_o,
  input  logic [NREQ-1:0]              req_ch_i,
  input  logic [NREQ-1:0][SPI_DW-1:0]  req_wr_h_i,
  input  logic [NREQ-1:0][SPI_DW-1:0]  req_wr_l_i,
  output logic [NREQ-1:0]              rsp_valid_o,
  output logic [SPI_DW-1:0]            rsp_data_o,
  output logic                         rsp_err_o,
  output logic [1:0]                   spi_start_o,
  output logic [1:0][SPI_DW-1:0]       spi_wr_h_o,
  output logic [1:0][SPI_DW-1:0]       spi_wr_l_o,
  input  logic [1:0][SPI_DW-1:0]       spi_rd_l_i,
  input  logic [1:0]                   spi_bsy_i
`ifdef HK_SPI_ARB_STATS_EN
  ,
  output logic [31:0]                  stat_xfer_o,
  output logic [15:0]                  stat_tmo_o,
  output logic [15:0]                  stat_last_lat_o
`endif
);

  localparam int IW = (clog2(NREQ) < 1) ? 1 : clog2(NREQ);
  localparam int CW = clog2(TMO_CYC) + 1;

  arb_state_e      state;
  logic [IW-1:0]   ptr, g_q, gnt_idx;
  logic [NREQ-1:0] gnt;
  logic            ch_q, sel_ch, bsy_sel, run_q;
  logic [CW-1:0]   cnt, cnt_inc;

  // run_q holds off grants until the first cycle after reset release, so
  // the combinational accept stays 0 while reset is asserted.
  hk_rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req     (req_valid_i),
    .ptr     (ptr),
    .en      (run_q && (state == S_IDLE)),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready_o = gnt;
  assign sel_ch      = req_ch_i[gnt_idx];
  assign bsy_sel     = spi_bsy_i[ch_q];
  // cnt always stays below TMO_CYC (the FSM leaves on reaching it), so the
  // increment cannot wrap.
  assign cnt_inc     = cnt + CW'(1);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= S_IDLE;
      ptr         <= IW'(NREQ - 1);
      g_q         <= '0;
      ch_q        <= 1'(CH_ADC);
      cnt         <= '0;
      run_q       <= 1'b0;
      spi_start_o <= '0;
      spi_wr_h_o  <= '0;
      spi_wr_l_o  <= '0;
      rsp_valid_o <= '0;
      rsp_data_o  <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      run_q       <= 1'b1;
      spi_start_o <= '0;
      rsp_valid_o <= '0;
      case (state)
        S_IDLE: if (|gnt) begin
          g_q                <= gnt_idx;
          ch_q               <= sel_ch;
          ptr                <= gnt_idx;
          spi_wr_h_o[sel_ch] <= req_wr_h_i[gnt_idx];
          spi_wr_l_o[sel_ch] <= req_wr_l_i[gnt_idx];
          spi_start_o[sel_ch] <= 1'b1;   // visible during START
          state              <= S_START;
        end
        S_START: begin
          cnt   <= '0;
          state <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          if (bsy_sel) begin
            cnt   <= '0;
            state <= S_WAIT_LO;
          end else if (cnt_inc >= CW'(BSY_WIN)) begin
            rsp_err_o        <= 1'b1;
            rsp_data_o       <= '0;
            rsp_valid_o[g_q] <= 1'b1;
            state            <= S_RESP;
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_WAIT_LO: begin
          if (!bsy_sel) begin
            rsp_err_o        <= 1'b0;
            rsp_data_o       <= spi_rd_l_i[ch_q];
            rsp_valid_o[g_q] <= 1'b1;
            state            <= S_RESP;
          end else if (cnt_inc >= CW'(TMO_CYC)) begin
            rsp_err_o        <= 1'b1;
            rsp_data_o       <= '0;
            rsp_valid_o[g_q] <= 1'b1;
            state            <= S_RESP;
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef HK_SPI_ARB_STATS_EN
  // lat_cnt starts at 2 on accept so that in the RESP cycle it equals the
  // inclusive cycle count from the accept cycle to the RESP cycle.
  logic [15:0] lat_cnt;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      lat_cnt         <= '0;
      stat_xfer_o     <= '0;
      stat_tmo_o      <= '0;
      stat_last_lat_o <= '0;
    end else begin
      if (state == S_IDLE && |gnt)
        lat_cnt <= 16'd2;
      else if (state != S_IDLE && state != S_RESP && lat_cnt != 16'hFFFF)
        lat_cnt <= lat_cnt + 16'd1;
      if (state == S_RESP) begin
        stat_xfer_o     <= stat_xfer_o + 32'd1;
        stat_last_lat_o <= lat_cnt;
        if (rsp_err_o && stat_tmo_o != 16'hFFFF)
          stat_tmo_o <= stat_tmo_o + 16'd1;
      end
    end
  end
`else
  // Statistics counters are not built.
`endif

endmodule
